// File: rtl/ps2_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx_ctrl
//  Description : PS/2 device-to-host receive controller. Synchronises and
//                deglitches the raw PS/2 lines, frames 11-bit packets
//                (start, 8 data LSB-first, odd parity, stop), buffers good
//                scancodes in a first-word-fall-through FIFO and reports
//                parity, framing/timeout and overflow errors as sticky flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_ctrl #(
    parameter int FIFO_DEPTH = 8,       // scancode FIFO entries, power of 2, >= 2
    parameter int FILT_LEN   = 4,       // equal samples required to accept a ps2_clk level
    parameter int TIMEOUT    = 25000    // max cycles between clock falls inside a frame
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       rd_ready,
    input  logic       clr_err,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int PW = $clog2(FIFO_DEPTH);        // FIFO pointer width
    localparam int CW = PW + 1;                    // FIFO occupancy width
    localparam int FW = $clog2(FILT_LEN + 1);      // glitch filter counter width
    localparam int TW = $clog2(TIMEOUT + 1);       // inter-bit timeout counter width

    localparam logic [FW-1:0] c_FILT_MAX  = FW'(FILT_LEN - 1);
    localparam logic [TW-1:0] c_TMO_LIMIT = TW'(TIMEOUT);
    localparam logic [CW-1:0] c_FIFO_FULL = CW'(FIFO_DEPTH);

    // ------------------------------------------------------------------------
    // Frame FSM encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Signal declarations
    // ------------------------------------------------------------------------
    logic          r_clk_s1;
    logic          r_clk_s2;
    logic          r_dat_s1;
    logic          r_dat_s2;
    logic          r_filt_clk;
    logic [FW-1:0] r_filt_cnt;
    logic          w_fall;
    logic          w_dat;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_bitcnt;
    logic [2:0]    w_bitcnt_nxt;
    logic [7:0]    r_shreg;
    logic [7:0]    w_shreg_nxt;
    logic          r_par_ok;
    logic          w_par_ok_nxt;
    logic [TW-1:0] r_tmo;
    logic          w_timeout;

    logic          w_push_req;
    logic          w_set_par;
    logic          w_set_frm;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_set_ovf;

    logic          r_par_err;
    logic          r_frm_err;
    logic          r_ovf;

    // ------------------------------------------------------------------------
    // Two-flop synchronisers; lines idle high so reset to 1
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // ------------------------------------------------------------------------
    // Glitch filter: accept a new ps2_clk level after FILT_LEN consecutive
    // samples that disagree with the current filtered level
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_s2 != r_filt_clk) begin
            if (r_filt_cnt == c_FILT_MAX) begin
                r_filt_clk <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
        end else begin
            r_filt_cnt <= '0;
        end
    end

    // The fall strobe is the cycle in which the filtered clock flips 1->0;
    // the synchronised data line is sampled in that same cycle.
    assign w_fall = r_filt_clk && !r_clk_s2 && (r_filt_cnt == c_FILT_MAX);
    assign w_dat  = r_dat_s2;

    // Abort a frame once TIMEOUT cycles have passed since the last fall
    assign w_timeout = (r_state != S_IDLE) && (r_tmo == c_TMO_LIMIT);

    // ------------------------------------------------------------------------
    // Inter-bit timeout counter: held at zero while idle, restarted by a fall
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tmo <= '0;
        end else if ((r_state == S_IDLE) || w_fall) begin
            r_tmo <= '0;
        end else if (!w_timeout) begin
            r_tmo <= r_tmo + TW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM state and shift register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_shreg  <= '0;
            r_par_ok <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shreg  <= w_shreg_nxt;
            r_par_ok <= w_par_ok_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM next state, data capture and event strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shreg_nxt  = r_shreg;
        w_par_ok_nxt = r_par_ok;
        w_push_req   = 1'b0;
        w_set_par    = 1'b0;
        w_set_frm    = 1'b0;

        if (w_fall) begin
            case (r_state)
                S_IDLE: begin
                    // A fall with data high is a spurious edge, not a start bit
                    if (!w_dat) begin
                        w_state_nxt  = S_DATA;
                        w_bitcnt_nxt = '0;
                    end
                end
                S_DATA: begin
                    w_shreg_nxt[r_bitcnt] = w_dat;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                    end
                end
                S_PARITY: begin
                    // Odd parity: data plus parity bit must hold an odd count of ones
                    w_par_ok_nxt = ^{r_shreg, w_dat};
                    w_state_nxt  = S_STOP;
                end
                S_STOP: begin
                    if (w_dat) begin
                        if (r_par_ok) begin
                            w_push_req = 1'b1;
                        end else begin
                            w_set_par = 1'b1;
                        end
                    end else begin
                        w_set_frm = 1'b1;
                        if (!r_par_ok) begin
                            w_set_par = 1'b1;
                        end
                    end
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end else if (w_timeout) begin
            // Partial byte is simply abandoned; the shift register is reloaded next frame
            w_state_nxt = S_IDLE;
            w_set_frm   = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO control: a push into a full FIFO only succeeds if a pop frees a slot
    // in the same cycle; otherwise the byte is dropped and overflow is flagged
    // ------------------------------------------------------------------------
    assign w_full    = (r_count == c_FIFO_FULL);
    assign w_pop     = rd_valid && rd_ready;
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_set_ovf = w_push_req && w_full && !w_pop;

    // FIFO storage, written without reset (contents are don't-care when empty)
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_shreg_nxt;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error flags; a set event outranks a simultaneous clear
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_set_par) begin
                r_par_err <= 1'b1;
            end else if (clr_err) begin
                r_par_err <= 1'b0;
            end
            if (w_set_frm) begin
                r_frm_err <= 1'b1;
            end else if (clr_err) begin
                r_frm_err <= 1'b0;
            end
            if (w_set_ovf) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rd_valid   = (r_count != '0);
    assign rd_data    = r_mem[r_rd_ptr];
    assign parity_err = r_par_err;
    assign frame_err  = r_frm_err;
    assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_rx_ctrl
//  Description : Directed self-checking bench for ps2_rx_ctrl. Drives PS/2
//                frames bit by bit and compares FIFO and flag outputs with
//                hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_ctrl;

    localparam int HALF = 20;   // system clocks per PS/2 clock half-period

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready;
    logic       clr_err;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    ps2_rx_ctrl #(
        .FIFO_DEPTH (8),
        .FILT_LEN   (4),
        .TIMEOUT    (25000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .clr_err    (clr_err),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    // Global watchdog so the run can never hang
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One PS/2 bit: data set while clock high, then one low and one high half.
    // With glitch set, a one-cycle opposite pulse is inserted in each half.
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_dat = b;
        if (glitch) begin
            wait_cyc(12); ps2_clk = 1'b0; wait_cyc(1); ps2_clk = 1'b1; wait_cyc(HALF - 13);
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk = 1'b0;
        if (glitch) begin
            wait_cyc(12); ps2_clk = 1'b1; wait_cyc(1); ps2_clk = 1'b0; wait_cyc(HALF - 13);
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    // Full 11-bit frame; parity is odd unless bad_par inverts it
    task automatic send_frame(input logic [7:0] data, input bit bad_par,
                              input logic stop, input bit glitch);
        logic p;
        p = (~^data) ^ bad_par;
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(data[i], glitch);
        ps2_bit(p, glitch);
        ps2_bit(stop, glitch);
        ps2_dat = 1'b1;
        wait_cyc(10);
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        wait_cyc(1);
        rd_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        wait_cyc(1);
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; rd_ready = 1'b0; clr_err = 1'b0;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);
        n_checks++; if (rd_valid !== 1'b0)   begin n_errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_checks++; if (parity_err !== 1'b0) begin n_errors++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
        n_checks++; if (frame_err !== 1'b0)  begin n_errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_checks++; if (overflow !== 1'b0)   begin n_errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_good_frame();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        n_checks++; if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL good_valid: got %b want 1", rd_valid); end
        n_checks++; if (rd_data !== 8'h1C) begin n_errors++; $display("FAIL good_data: got %h want 1c", rd_data); end
        n_checks++; if ({parity_err, frame_err, overflow} !== 3'b000) begin
            n_errors++; $display("FAIL good_flags: got %b want 000", {parity_err, frame_err, overflow}); end
        pop_one();
        n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL good_empty: got %b want 0", rd_valid); end
    endtask

    task automatic test_parity_err();
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        n_checks++; if (rd_valid !== 1'b0)   begin n_errors++; $display("FAIL par_no_push: got %b want 0", rd_valid); end
        n_checks++; if (parity_err !== 1'b1) begin n_errors++; $display("FAIL par_flag: got %b want 1", parity_err); end
        n_checks++; if (frame_err !== 1'b0)  begin n_errors++; $display("FAIL par_frame_flag: got %b want 0", frame_err); end
        pulse_clr();
        n_checks++; if (parity_err !== 1'b0) begin n_errors++; $display("FAIL par_clear: got %b want 0", parity_err); end
    endtask

    task automatic test_stop_err();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        n_checks++; if (rd_valid !== 1'b0)   begin n_errors++; $display("FAIL stop_no_push: got %b want 0", rd_valid); end
        n_checks++; if (frame_err !== 1'b1)  begin n_errors++; $display("FAIL stop_flag: got %b want 1", frame_err); end
        n_checks++; if (parity_err !== 1'b0) begin n_errors++; $display("FAIL stop_par_flag: got %b want 0", parity_err); end
        pulse_clr();
        send_frame(8'h12, 1'b0, 1'b1, 1'b0);
        n_checks++; if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL stop_next_valid: got %b want 1", rd_valid); end
        n_checks++; if (rd_data !== 8'h12) begin n_errors++; $display("FAIL stop_next_data: got %h want 12", rd_data); end
        n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL stop_cleared: got %b want 0", frame_err); end
        pop_one();
    endtask

    task automatic test_timeout();
        logic [7:0] partial;
        partial = 8'h05;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(partial[i], 1'b0);
        ps2_dat = 1'b1;
        // About 24914 cycles after the last filtered fall: not yet timed out
        wait_cyc(24900);
        n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL tmo_early: got %b want 0", frame_err); end
        wait_cyc(200);
        n_checks++; if (frame_err !== 1'b1) begin n_errors++; $display("FAIL tmo_flag: got %b want 1", frame_err); end
        n_checks++; if (rd_valid !== 1'b0)  begin n_errors++; $display("FAIL tmo_no_push: got %b want 0", rd_valid); end
        pulse_clr();
        send_frame(8'h29, 1'b0, 1'b1, 1'b0);
        n_checks++; if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL tmo_next_valid: got %b want 1", rd_valid); end
        n_checks++; if (rd_data !== 8'h29) begin n_errors++; $display("FAIL tmo_next_data: got %h want 29", rd_data); end
        n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL tmo_next_flag: got %b want 0", frame_err); end
        pop_one();
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 8; k++) send_frame(8'(k), 1'b0, 1'b1, 1'b0);
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_at_full: got %b want 0", overflow); end
        send_frame(8'h09, 1'b0, 1'b1, 1'b0);
        n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        for (int k = 1; k <= 8; k++) begin
            n_checks++; if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL ovf_valid_%0d: got %b want 1", k, rd_valid); end
            n_checks++; if (rd_data !== 8'(k)) begin n_errors++; $display("FAIL ovf_data_%0d: got %h want %h", k, rd_data, 8'(k)); end
            pop_one();
        end
        n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_drained: got %b want 0", rd_valid); end
        pop_one();
        n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_pop_empty: got %b want 0", rd_valid); end
        pulse_clr();
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_glitch_and_reset();
        send_frame(8'h3A, 1'b0, 1'b1, 1'b1);
        n_checks++; if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL glitch_valid: got %b want 1", rd_valid); end
        n_checks++; if (rd_data !== 8'h3A) begin n_errors++; $display("FAIL glitch_data: got %h want 3a", rd_data); end
        n_checks++; if ({parity_err, frame_err} !== 2'b00) begin
            n_errors++; $display("FAIL glitch_flags: got %b want 00", {parity_err, frame_err}); end
        // Leave 0x3A queued, raise a flag, then reset in the middle of a frame
        send_frame(8'h77, 1'b0, 1'b0, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b1, 1'b0);
        reset = 1'b1;
        wait_cyc(2);
        n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid: got %b want 0", rd_valid); end
        n_checks++; if ({parity_err, frame_err, overflow} !== 3'b000) begin
            n_errors++; $display("FAIL midrst_flags: got %b want 000", {parity_err, frame_err, overflow}); end
        ps2_dat = 1'b1;
        ps2_clk = 1'b1;
        reset   = 1'b0;
        wait_cyc(5);
        send_frame(8'h44, 1'b0, 1'b1, 1'b0);
        n_checks++; if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL midrst_next_valid: got %b want 1", rd_valid); end
        n_checks++; if (rd_data !== 8'h44) begin n_errors++; $display("FAIL midrst_next_data: got %h want 44", rd_data); end
        n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL midrst_next_flag: got %b want 0", frame_err); end
        pop_one();
        n_checks++; if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_empty: got %b want 0", rd_valid); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_stop_err();
        test_timeout();
        test_overflow();
        test_glitch_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
